mem_port_arbiter: RTL and testbench

Shares the core's single memory port between instruction fetch (read-only) and the load/store path driven by the decoder's `mem_re`/`mem_we` controls. Serialises accesses with one outstanding transaction, gives data priority over fetch with optional anti-starvation, and routes each response back to its owner. Sits between the fetch/load-store stages and the memory interface.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/arb_starve_cnt.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the memory port arbiter.
// ARB_FAIR_EN (top-level build macro) selects fair arbitration; nothing here depends on it.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of IDLE arbitrations that fetch has lost to data while requesting.
// Only instantiated when ARB_FAIR_EN is defined.
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_i,
  input  logic if_req_i,
  input  logic if_win_i,
  input  logic d_win_i,
  output logic starved_o
);

  localparam int W = $clog2(STARVE_MAX + 1);
  localparam logic [W-1:0] CNT_MAX = W'(STARVE_MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // A fetch that stops asking, or finally wins, forgets its history.
  always_comb begin
    cnt_d = cnt_q;
    if (!if_req_i || if_win_i) begin
      cnt_d = '0;
    end else if (arb_i && d_win_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in flight.
// Define ARB_FAIR_EN to let a starved fetch beat data; otherwise data has strict priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a requester holds *_req and its payload until the one-cycle
  // *_gnt; the memory side holds mem_req with a stable payload until
  // mem_ready, and the single response is the next mem_rvalid seen in WAIT.

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        starved;
  logic        pick_if;
  logic        pick_d;

`ifdef ARB_FAIR_EN
  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .arb_i    (state_q == ST_IDLE),
    .if_req_i (if_req),
    .if_win_i (if_gnt),
    .d_win_i  (d_gnt),
    .starved_o(starved)
  );
`else
  assign starved = (STARVE_MAX < 0);
`endif

  assign pick_if = if_req && (!d_req || starved);
  assign pick_d  = d_req && !pick_if;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    mem_req   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_d) begin
          d_gnt   = 1'b1;
          owner_d = OWN_D;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          wstrb_d = d_wstrb;
          state_d = ST_ISSUE;
        end else if (pick_if) begin
          // Fetch is read-only: no write data or byte enables reach memory.
          if_gnt  = 1'b1;
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
          wdata_d = '0;
          wstrb_d = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          if_rvalid = (owner_q == OWN_IF);
          d_rvalid  = (owner_q == OWN_D);
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = wstrb_q;
  assign if_rdata    = mem_rdata;
  assign d_rdata     = mem_rdata;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
// Build with ARB_FAIR_EN defined to exercise fair arbitration.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
`ifdef ARB_FAIR_EN
  localparam int EXP_FIRST_IF = 5;
`else
  localparam int EXP_FIRST_IF = 0;
`endif

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_wstrb    (d_wstrb),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight; exp_q holds owners in grant order.
  logic        m_busy, m_acc, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  int          m_starve;
  logic [31:0] exp_q[$];

  function automatic logic m_starved();
`ifdef ARB_FAIR_EN
    return m_starve == STARVE_MAX;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic e_if_gnt();
    return !m_busy && if_req && (!d_req || m_starved());
  endfunction

  function automatic logic e_d_gnt();
    return !m_busy && d_req && !e_if_gnt();
  endfunction

  function automatic logic e_resp();
    return m_busy && m_acc && mem_rvalid && (exp_q.size() > 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_acc    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
      m_starve <= 0;
      exp_q.delete();
    end else begin
      if (e_d_gnt()) begin
        m_busy  <= 1'b1;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_wstrb <= d_wstrb;
        exp_q.push_back(32'd1);
      end else if (e_if_gnt()) begin
        m_busy  <= 1'b1;
        m_we    <= 1'b0;
        m_addr  <= if_addr;
        m_wdata <= '0;
        m_wstrb <= '0;
        exp_q.push_back(32'd0);
      end else if (m_busy && !m_acc && mem_ready) begin
        m_acc <= 1'b1;
      end else if (e_resp()) begin
        m_busy <= 1'b0;
        m_acc  <= 1'b0;
        void'(exp_q.pop_front());
      end
      if (!if_req || e_if_gnt()) m_starve <= 0;
      else if (e_d_gnt() && m_starve < STARVE_MAX) m_starve <= m_starve + 1;
    end
  end

  // Scoreboard compare, every cycle out of reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("if_gnt", {31'd0, if_gnt}, {31'd0, e_if_gnt()});
      chk("d_gnt", {31'd0, d_gnt}, {31'd0, e_d_gnt()});
      chk("mem_req", {31'd0, mem_req}, {31'd0, m_busy && !m_acc});
      chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, e_resp() && exp_q[0] == 32'd0});
      chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, e_resp() && exp_q[0] == 32'd1});
      chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, m_wstrb});
      chk("if_rdata", if_rdata, mem_rdata);
      chk("d_rdata", d_rdata, mem_rdata);
    end
  end

  // Driver: memory responder answers one cycle after acceptance when auto_resp is set
  logic        auto_resp;
  logic [31:0] resp_data;

  task automatic adv();
    logic acc;
    acc = mem_req && mem_ready;
    @(posedge clk);
    #1;
    if (auto_resp) begin
      mem_rvalid = acc;
      mem_rdata  = acc ? resp_data : $urandom;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  int arb;
  int first_if;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_ready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; auto_resp = 1'b0; resp_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    adv();

    // Fetch only
    mem_ready = 1'b1; auto_resp = 1'b1; resp_data = 32'h0000_0013;
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk); chk("fo_if_gnt_c0", {31'd0, if_gnt}, 32'd1); adv();
    if_req = 1'b0;
    @(negedge clk);
    chk("fo_mem_req_c1", {31'd0, mem_req}, 32'd1);
    chk("fo_mem_addr_c1", mem_addr, 32'h100);
    adv();
    @(negedge clk);
    chk("fo_if_rvalid_c2", {31'd0, if_rvalid}, 32'd1);
    chk("fo_if_rdata_c2", if_rdata, 32'h13);
    adv();

    // Collision: data first, fetch at next IDLE
    resp_data = 32'hA5A5_0001;
    if_req = 1'b1; if_addr = 32'h104; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    @(negedge clk);
    chk("col_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("col_if_gnt_c0", {31'd0, if_gnt}, 32'd0);
    adv();
    d_req = 1'b0;
    @(negedge clk); chk("col_mem_addr", mem_addr, 32'h2000); adv();
    @(negedge clk);
    chk("col_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("col_if_rvalid_c2", {31'd0, if_rvalid}, 32'd0);
    adv();
    @(negedge clk); chk("col_if_gnt_next", {31'd0, if_gnt}, 32'd1); adv();
    if_req = 1'b0;
    @(negedge clk); adv();
    @(negedge clk); chk("col_if_rvalid", {31'd0, if_rvalid}, 32'd1); adv();

    // Store with memory stalling three cycles; a fetch blip while busy is ignored
    resp_data = 32'h0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    mem_ready = 1'b0;
    @(negedge clk); chk("st_d_gnt", {31'd0, d_gnt}, 32'd1); adv();
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    if_req = 1'b1; if_addr = 32'h200;
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) if_req = 1'b0;
      if (i == 4) mem_ready = 1'b1;
      @(negedge clk);
      chk("st_mem_req", {31'd0, mem_req}, 32'd1);
      chk("st_mem_we", {31'd0, mem_we}, 32'd1);
      chk("st_mem_addr", mem_addr, 32'h40);
      chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st_mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
      adv();
    end
    @(negedge clk); chk("st_d_rvalid", {31'd0, d_rvalid}, 32'd1); adv();
    @(negedge clk); chk("st_no_if_gnt", {31'd0, if_gnt}, 32'd0); adv();

    // Spurious mem_rvalid in IDLE
    auto_resp = 1'b0; mem_rvalid = 1'b1;
    @(negedge clk);
    chk("sp_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("sp_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    adv();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("sp_state", {30'd0, dbg_state}, 32'd0);
    chk("sp_mem_req", {31'd0, mem_req}, 32'd0);
    adv();

    // Reset while waiting for a fetch response
    if_req = 1'b1; if_addr = 32'h300;
    @(negedge clk); chk("rs_if_gnt", {31'd0, if_gnt}, 32'd1); adv();
    if_req = 1'b0;
    @(negedge clk); adv();
    @(negedge clk); chk("rs_waiting", {31'd0, mem_req}, 32'd0); adv();
    rst = 1'b1;
    @(negedge clk); adv();
    rst = 1'b0; mem_rvalid = 1'b1;
    @(negedge clk);
    chk("rs_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rs_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rs_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rs_mem_addr", mem_addr, 32'd0);
    adv();
    mem_rvalid = 1'b0; auto_resp = 1'b1; resp_data = 32'h1234_5678;
    if_req = 1'b1; if_addr = 32'h400;
    @(negedge clk); chk("rs_regrant", {31'd0, if_gnt}, 32'd1); adv();
    if_req = 1'b0;
    @(negedge clk); chk("rs_mem_addr2", mem_addr, 32'h400); adv();
    @(negedge clk); chk("rs_if_rvalid2", {31'd0, if_rvalid}, 32'd1); adv();

    // Starvation: both request continuously for six arbitrations
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; if_req = 1'b1; if_addr = 32'h500;
    arb = 0; first_if = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        arb++;
        if (if_gnt && first_if == 0) first_if = arb;
      end
      adv();
    end
    chk("starve_arbs", arb, 32'd6);
    chk("starve_first_if", first_if, EXP_FIRST_IF);
    d_req = 1'b0; if_req = 1'b0;
    repeat (4) begin
      @(negedge clk); adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
